if_fetch: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline and the producer side of the IF/ID register. It generates the PC, runs a req/ack handshake with instruction memory, and presents {pc_if, inst_if, en_if} to IF/ID. It honours downstream stalls through a 1-entry skid buffer and handles branch redirects, including redirects that arrive while a memory request is still outstanding.

---
 rtl/if_fetch.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding IF/ID: PC generation, imem req/ack handshake,
// a 1-entry skid buffer for downstream stalls, and branch redirects (also mid-request).

module if_fetch_chk #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              reset_,
  input logic              stall,
  input logic              br_taken,
  input logic              imem_req,
  input logic              imem_ack,
  input logic [ADDR_W-1:0] imem_addr,
  input logic [ADDR_W-1:0] pc_if,
  input logic [DATA_W-1:0] inst_if,
  input logic              en_if
);

  // An outstanding request is never withdrawn and its address never moves before ack.
  property p_req_held;
    @(posedge clk) disable iff (reset_)
      (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr));
  endproperty
  a_req_held: assert property (p_req_held);

  // A stalled, valid instruction stays bit-stable unless a redirect flushes it.
  property p_out_frozen;
    @(posedge clk) disable iff (reset_)
      (en_if && stall && !br_taken) |=> (en_if && $stable(pc_if) && $stable(inst_if));
  endproperty
  a_out_frozen: assert property (p_out_frozen);

endmodule

module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_if,
  output logic [DATA_W-1:0] inst_if,
  output logic              en_if
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t              state_r,     state_s;
  logic [ADDR_W-1:0]   req_pc_r,    req_pc_s;
  logic [ADDR_W-1:0]   redir_pc_r,  redir_pc_s;
  logic [ADDR_W-1:0]   skid_pc_r,   skid_pc_s;
  logic [DATA_W-1:0]   skid_inst_r, skid_inst_s;
  logic [ADDR_W-1:0]   pc_if_s;
  logic [DATA_W-1:0]   inst_if_s;
  logic                en_if_s;
  logic [ADDR_W-1:0]   br_target_s;
  logic [ADDR_W-1:0]   pc_next_s;
  logic                consume_s;
  logic                slot_free_s;

  assign br_target_s = br_addr & ALIGN_MASK;
  assign pc_next_s   = req_pc_r + PC_STEP;
  assign consume_s   = en_if && !stall;
  assign slot_free_s = !en_if || !stall;

  // Memory request is a pure decode of state and req_pc; DRAIN keeps the old address up.
  assign imem_req  = (state_r == ST_FETCH) || (state_r == ST_DRAIN);
  assign imem_addr = req_pc_r;

  // Next-state and next-register decode for the fetch controller.
  always_comb begin
    state_s     = state_r;
    req_pc_s    = req_pc_r;
    redir_pc_s  = redir_pc_r;
    skid_pc_s   = skid_pc_r;
    skid_inst_s = skid_inst_r;
    pc_if_s     = pc_if;
    inst_if_s   = inst_if;
    en_if_s     = en_if;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (br_taken) begin
          en_if_s = 1'b0;
          if (imem_ack) begin
            req_pc_s = br_target_s;
          end else begin
            redir_pc_s = br_target_s;
            state_s    = ST_DRAIN;
          end
        end else if (imem_ack) begin
          req_pc_s = pc_next_s;
          if (slot_free_s) begin
            pc_if_s   = req_pc_r;
            inst_if_s = imem_rdata;
            en_if_s   = 1'b1;
          end else begin
            skid_pc_s   = req_pc_r;
            skid_inst_s = imem_rdata;
            state_s     = ST_FULL;
          end
        end else if (consume_s) begin
          en_if_s = 1'b0;
        end else begin
          en_if_s = en_if;
        end
      end
      ST_FULL: begin
        if (br_taken) begin
          en_if_s  = 1'b0;
          req_pc_s = br_target_s;
          state_s  = ST_FETCH;
        end else if (!stall) begin
          pc_if_s   = skid_pc_r;
          inst_if_s = skid_inst_r;
          en_if_s   = 1'b1;
          state_s   = ST_FETCH;
        end else begin
          state_s = ST_FULL;
        end
      end
      ST_DRAIN: begin
        en_if_s = 1'b0;
        if (br_taken) begin
          redir_pc_s = br_target_s;
        end else begin
          redir_pc_s = redir_pc_r;
        end
        // A redirect landing on the drain ack is the most recent one and wins.
        if (imem_ack) begin
          req_pc_s = br_taken ? br_target_s : redir_pc_r;
          state_s  = ST_FETCH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Fetch PC, redirect target, skid entry and IF/ID output registers.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      req_pc_r    <= RESET_PC;
      redir_pc_r  <= '0;
      skid_pc_r   <= '0;
      skid_inst_r <= '0;
      pc_if       <= '0;
      inst_if     <= '0;
      en_if       <= 1'b0;
    end else begin
      req_pc_r    <= req_pc_s;
      redir_pc_r  <= redir_pc_s;
      skid_pc_r   <= skid_pc_s;
      skid_inst_r <= skid_inst_s;
      pc_if       <= pc_if_s;
      inst_if     <= inst_if_s;
      en_if       <= en_if_s;
    end
  end

  if_fetch_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_chk (
    .clk       (clk),
    .reset_    (reset_),
    .stall     (stall),
    .br_taken  (br_taken),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_addr (imem_addr),
    .pc_if     (pc_if),
    .inst_if   (inst_if),
    .en_if     (en_if)
  );

endmodule
